divider_sequencer: RTL and testbench

- Sequences the programmable clock divider through a stored list of (divide count, duration) steps, e.g. tone or blink patterns.
- Drives the divider's div_clk_count and run inputs. Its div_run output connects to the divider's Reset pin, which is active-high run.
- A host writes a step table, then issues start or stop. The block plays the table once or in a loop and reports progress.

---
 rtl/divider_sequencer_pkg.sv | 9 +
 rtl/divider_step_table.sv | 43 ++++
 rtl/divider_sequencer.sv | 106 ++++++++++
 tb/tb_divider_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/divider_sequencer_pkg.sv
// divider_sequencer_pkg: shared sizes, reset defaults and FSM states for the divider sequencer
package divider_sequencer_pkg;
  localparam int DEPTH = 8;
  localparam int CNT_W = 32;
  localparam int DUR_W = 32;
  localparam int DEF_COUNT = 1;
  localparam int DEF_DUR = 1;
  typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} state_t;
endpackage

// File: rtl/divider_step_table.sv
// divider_step_table: step table with a guarded write port and a combinational read port
module divider_step_table
  import divider_sequencer_pkg::*;
#(
  parameter int DEPTH = divider_sequencer_pkg::DEPTH,
  parameter int CNT_W = divider_sequencer_pkg::CNT_W,
  parameter int DUR_W = divider_sequencer_pkg::DUR_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [CNT_W-1:0] i_wr_count,
  input  logic [DUR_W-1:0] i_wr_dur,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [CNT_W-1:0] o_rd_count,
  output logic [DUR_W-1:0] o_rd_dur,
  output logic             o_wr_err
);
  logic [CNT_W-1:0] r_count [DEPTH];
  logic [DUR_W-1:0] r_dur [DEPTH];
  logic             w_zero;
  assign w_zero = i_wr_count == '0;
  assign o_rd_count = r_count[i_rd_addr];
  assign o_rd_dur = r_dur[i_rd_addr];
  // a zero count would underflow the divider compare, so such writes are dropped
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_count[i] <= CNT_W'(DEF_COUNT);
        r_dur[i] <= DUR_W'(DEF_DUR);
      end
      o_wr_err <= 1'b0;
    end else begin
      o_wr_err <= i_wr_en && w_zero;
      if (i_wr_en && !w_zero) begin
        r_count[i_wr_addr] <= i_wr_count;
        r_dur[i_wr_addr] <= i_wr_dur;
      end
    end
  end
endmodule

// File: rtl/divider_sequencer.sv
// divider_sequencer: plays a (count, duration) step table into a programmable clock divider
module divider_sequencer
  import divider_sequencer_pkg::*;
#(
  parameter int DEPTH = divider_sequencer_pkg::DEPTH,
  parameter int CNT_W = divider_sequencer_pkg::CNT_W,
  parameter int DUR_W = divider_sequencer_pkg::DUR_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             inclk,
  input  logic             Reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [CNT_W-1:0] wr_count,
  input  logic [DUR_W-1:0] wr_dur,
  output logic             wr_err,
  input  logic [AW:0]      len,
  input  logic             loop_en,
  input  logic             start,
  input  logic             stop,
  output logic             cfg_err,
  output logic [CNT_W-1:0] div_clk_count,
  output logic             div_run,
  output logic             busy,
  output logic [AW-1:0]    step_idx,
  output logic             done
);
  state_t           r_state;
  logic [AW:0]      r_len;
  logic [AW-1:0]    r_idx;
  logic [DUR_W-1:0] r_left;
  logic [CNT_W-1:0] r_count;
  logic             r_done;
  logic             r_cfg_err;
  logic             w_last_step;
  logic             w_step_end;
  logic             w_len_ok;
  logic [AW-1:0]    w_next_idx;
  logic [AW-1:0]    w_rd_addr;
  logic [CNT_W-1:0] w_rd_count;
  logic [DUR_W-1:0] w_rd_dur;
  logic [DUR_W-1:0] w_load_dur;
  divider_step_table #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DUR_W(DUR_W)) u_table (
    .i_clk(inclk),
    .i_rst(Reset),
    .i_wr_en(wr_en),
    .i_wr_addr(wr_addr),
    .i_wr_count(wr_count),
    .i_wr_dur(wr_dur),
    .i_rd_addr(w_rd_addr),
    .o_rd_count(w_rd_count),
    .o_rd_dur(w_rd_dur),
    .o_wr_err(wr_err)
  );
  assign w_last_step = {1'b0, r_idx} == r_len - 1'b1;
  assign w_step_end = r_left == DUR_W'(1);
  assign w_len_ok = len != '0 && len <= (AW+1)'(DEPTH);
  assign w_next_idx = w_last_step ? '0 : r_idx + 1'b1;
  assign w_rd_addr = r_state == IDLE ? '0 : w_next_idx;
  assign w_load_dur = w_rd_dur == '0 ? DUR_W'(1) : w_rd_dur;
  assign busy = r_state == PLAY;
  assign div_run = r_state == PLAY;
  assign div_clk_count = r_count;
  assign step_idx = r_idx;
  assign done = r_done;
  assign cfg_err = r_cfg_err;
  // stop is checked ahead of start and of the step-end decision so it always wins
  always_ff @(posedge inclk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_len <= '0;
      r_idx <= '0;
      r_left <= DUR_W'(DEF_DUR);
      r_count <= CNT_W'(DEF_COUNT);
      r_done <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_cfg_err <= 1'b0;
      if (r_state == IDLE) begin
        if (start && !stop) begin
          if (w_len_ok) begin
            r_state <= PLAY;
            r_len <= len;
            r_idx <= '0;
            r_count <= w_rd_count;
            r_left <= w_load_dur;
          end else begin
            r_cfg_err <= 1'b1;
          end
        end
      end else if (stop) begin
        r_state <= IDLE;
      end else if (!w_step_end) begin
        r_left <= r_left - 1'b1;
      end else if (!w_last_step || loop_en) begin
        r_idx <= w_next_idx;
        r_count <= w_rd_count;
        r_left <= w_load_dur;
      end else begin
        r_state <= IDLE;
        r_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_divider_sequencer.sv
// tb_divider_sequencer: directed and randomized playback checks against a step-list model
module tb_divider_sequencer;
  logic        inclk = 1'b0;
  logic        Reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_count = '0;
  logic [31:0] wr_dur = '0;
  logic        wr_err;
  logic [3:0]  len = '0;
  logic        loop_en = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cfg_err;
  logic [31:0] div_clk_count;
  logic        div_run;
  logic        busy;
  logic [2:0]  step_idx;
  logic        done;
  int          total = 0;
  int          bad = 0;
  int unsigned m_cnt [8];
  int unsigned m_dur [8];
  divider_sequencer dut (
    .inclk(inclk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_count(wr_count),
    .wr_dur(wr_dur), .wr_err(wr_err), .len(len), .loop_en(loop_en), .start(start), .stop(stop),
    .cfg_err(cfg_err), .div_clk_count(div_clk_count), .div_run(div_run), .busy(busy),
    .step_idx(step_idx), .done(done)
  );
  always #5 inclk = ~inclk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge inclk);
    #1;
  endtask
  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_cnt[i] = 1;
      m_dur[i] = 1;
    end
  endtask
  task automatic wr(input int a, input int unsigned c, input int unsigned d);
    wr_en = 1'b1;
    wr_addr = 3'(a);
    wr_count = c;
    wr_dur = d;
    tick();
    wr_en = 1'b0;
    chk("wr_err", wr_err, 64'(c == 0));
    if (c != 0) begin
      m_cnt[a] = c;
      m_dur[a] = d;
    end
  endtask
  task automatic step(input int unsigned c, input int i);
    chk("step_count", div_clk_count, c);
    chk("step_idx", step_idx, i);
    chk("step_busy", busy, 1);
    chk("step_run", div_run, 1);
    chk("step_done", done, 0);
    tick();
  endtask
  task automatic play(input int n);
    int unsigned q_c[$];
    int q_i[$];
    for (int i = 0; i < n; i++)
      repeat (m_dur[i] == 0 ? 1 : m_dur[i]) begin
        q_c.push_back(m_cnt[i]);
        q_i.push_back(i);
      end
    len = 4'(n);
    loop_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    foreach (q_c[k]) step(q_c[k], q_i[k]);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_run", div_run, 0);
    chk("end_count_hold", div_clk_count, q_c[q_c.size()-1]);
    tick();
    chk("done_one_cycle", done, 0);
  endtask
  task automatic bad_start(input int n, input logic with_stop, input logic exp_err);
    len = 4'(n);
    start = 1'b1;
    stop = with_stop;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("rej_cfg_err", cfg_err, 64'(exp_err));
    chk("rej_busy", busy, 0);
    chk("rej_run", div_run, 0);
    tick();
    chk("cfg_err_one_cycle", cfg_err, 0);
  endtask
  initial begin
    model_reset();
    #12;
    chk("rst_count", div_clk_count, 1);
    chk("rst_run", div_run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", step_idx, 0);
    chk("rst_flags", {done, wr_err, cfg_err}, 0);
    @(negedge inclk);
    Reset = 1'b0;
    tick();
    wr(0, 5, 10);
    wr(1, 3, 4);
    play(2);
    len = 4'd2;
    loop_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) step(5, 0);
    repeat (4) step(3, 1);
    repeat (10) step(5, 0);
    repeat (2) step(3, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_run", div_run, 0);
    chk("stop_done", done, 0);
    tick();
    chk("stop_no_late_done", done, 0);
    wr(2, 0, 9);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) step(5, 0);
    wr_en = 1'b1;
    wr_addr = 3'd0;
    wr_count = 7;
    wr_dur = 2;
    step(5, 0);
    wr_en = 1'b0;
    m_cnt[0] = 7;
    m_dur[0] = 2;
    repeat (6) step(5, 0);
    repeat (4) step(3, 1);
    repeat (2) step(7, 0);
    repeat (4) step(3, 1);
    step(7, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop2_busy", busy, 0);
    play(3);
    bad_start(0, 1'b0, 1'b1);
    bad_start(9, 1'b0, 1'b1);
    bad_start(0, 1'b1, 1'b0);
    bad_start(2, 1'b1, 1'b0);
    len = 4'd2;
    loop_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) step(7, 0);
    step(3, 1);
    #3;
    Reset = 1'b1;
    #1;
    chk("async_count", div_clk_count, 1);
    chk("async_run", div_run, 0);
    chk("async_busy", busy, 0);
    chk("async_idx", step_idx, 0);
    model_reset();
    @(negedge inclk);
    Reset = 1'b0;
    play(1);
    play(2);
    for (int r = 0; r < 5; r++) begin
      for (int a = 0; a < 8; a++)
        wr(a, $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 1000), $urandom_range(0, 6));
      play($urandom_range(1, 8));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
